// File: rtl/array_ctrl_pkg.sv
// Shared defaults and types for the single-port array read/write controller.
package array_ctrl_pkg;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 516;
    localparam int unsigned SEG_N      = 2;
    localparam int unsigned SEG_W      = DATA_W / SEG_N;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned STARVE_W   = 3;
    localparam int unsigned RESP_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;

    // One buffered read response.
    typedef struct packed {
        logic [DATA_W-1:0] data;
    } resp_entry_t;

endpackage

// File: rtl/array_resp_fifo.sv
// Two-entry response FIFO holding read data until the requester accepts it.
module array_resp_fifo
#(
    parameter int unsigned DATA_W = array_ctrl_pkg::DATA_W
)
(
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               push_i,
    input  logic [DATA_W-1:0]                  push_data_i,
    input  logic                               pop_i,
    output logic [DATA_W-1:0]                  head_o,
    output logic                               valid_o,
    output logic [array_ctrl_pkg::CNT_W-1:0]   count_o
);
    import array_ctrl_pkg::*;

    logic [DATA_W-1:0] mem_q [RESP_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Pointer and occupancy next-state; push and pop together keep the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = CNT_W'(count_q + CNT_W'(push_i) - CNT_W'(pop_i));
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/array_rw_ctrl.sv
// Arbitrates write and read requests onto one array port and buffers read responses.
module array_rw_ctrl
#(
    parameter int unsigned ADDR_W     = array_ctrl_pkg::ADDR_W,
    parameter int unsigned DATA_W     = array_ctrl_pkg::DATA_W,
    parameter int unsigned SEG_N      = array_ctrl_pkg::SEG_N,
    parameter int unsigned STARVE_MAX = array_ctrl_pkg::STARVE_MAX
)
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [SEG_N-1:0]  wr_mask_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_valid_i,
    output logic              rd_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              RW0_en_o,
    output logic              RW0_wmode_o,
    output logic [ADDR_W-1:0] RW0_addr_o,
    output logic [SEG_N-1:0]  RW0_wmask_o,
    output logic [DATA_W-1:0] RW0_wdata_o,
    input  logic [DATA_W-1:0] RW0_rdata_i
);
    import array_ctrl_pkg::*;

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                inflight_q, inflight_d;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_valid;
    logic                fifo_push;
    logic                fifo_pop;
    logic                credit_ok;
    logic                read_wins;
    logic                write_wins;
    logic                rd_grant;
    logic                wr_grant;

    // Response credit counts buffered entries plus the read still in the array.
    assign credit_ok = (3'(fifo_count) + 3'(inflight_q)) < 3'd2;

    // Arbitration: write by default, read when starved or when no write is pending.
    always_comb begin
        read_wins  = 1'b0;
        write_wins = 1'b0;
        rd_grant   = 1'b0;
        wr_grant   = 1'b0;
        read_wins  = rd_valid_i && (!wr_valid_i || (starve_q == STARVE_W'(STARVE_MAX)));
        write_wins = wr_valid_i && !read_wins;
        rd_grant   = !reset_i && read_wins && credit_ok;
        wr_grant   = !reset_i && write_wins;
    end

    assign wr_ready_o = wr_grant;
    assign rd_ready_o = rd_grant;

    // Array command drive; an all-zero write mask suppresses the port enable.
    always_comb begin
        RW0_en_o    = 1'b0;
        RW0_wmode_o = 1'b0;
        RW0_addr_o  = '0;
        RW0_wmask_o = '0;
        RW0_wdata_o = '0;
        if (wr_grant) begin
            if (wr_mask_i != '0) begin
                RW0_en_o    = 1'b1;
                RW0_wmode_o = 1'b1;
                RW0_addr_o  = wr_addr_i;
                RW0_wmask_o = wr_mask_i;
                RW0_wdata_o = wr_data_i;
            end
        end else if (rd_grant) begin
            RW0_en_o   = 1'b1;
            RW0_addr_o = rd_addr_i;
        end
    end

    // Starvation counter and in-flight flag next-state.
    always_comb begin
        starve_d   = starve_q;
        inflight_d = rd_grant;
        if (!rd_valid_i || rd_grant) begin
            starve_d = '0;
        end else if (wr_grant && (starve_q < STARVE_W'(STARVE_MAX))) begin
            starve_d = STARVE_W'(starve_q + STARVE_W'(1));
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            starve_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            inflight_q <= inflight_d;
        end
    end

    // Array data lands one cycle after the read command; a read cut by reset is dropped.
    assign fifo_push    = inflight_q && !reset_i;
    assign fifo_pop     = fifo_valid && resp_ready_i && !reset_i;
    assign resp_valid_o = fifo_valid && !reset_i;

    array_resp_fifo #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clk_i       (clock_i),
        .rst_i       (reset_i),
        .push_i      (fifo_push),
        .push_data_i (RW0_rdata_i),
        .pop_i       (fifo_pop),
        .head_o      (resp_data_o),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_array_rw_ctrl.sv
// Directed bench for array_rw_ctrl with a behavioural masked single-port array.
module tb_array_rw_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 516;
    localparam int unsigned SN = 2;

    logic          clk;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [SN-1:0] wr_mask;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          RW0_en;
    logic          RW0_wmode;
    logic [AW-1:0] RW0_addr;
    logic [SN-1:0] RW0_wmask;
    logic [DW-1:0] RW0_wdata;
    logic [DW-1:0] RW0_rdata;

    logic [DW-1:0] mem [32];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] pat_a, pat_b, pat_c, pat_d1, pat_d2, pat_d3, pat_mix;

    array_rw_ctrl dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_addr_i    (wr_addr),
        .wr_mask_i    (wr_mask),
        .wr_data_i    (wr_data),
        .rd_valid_i   (rd_valid),
        .rd_ready_o   (rd_ready),
        .rd_addr_i    (rd_addr),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .RW0_en_o     (RW0_en),
        .RW0_wmode_o  (RW0_wmode),
        .RW0_addr_o   (RW0_addr),
        .RW0_wmask_o  (RW0_wmask),
        .RW0_wdata_o  (RW0_wdata),
        .RW0_rdata_i  (RW0_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: masked write, read data registered one cycle after the command.
    always @(posedge clk) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                if (RW0_wmask[0]) mem[RW0_addr][257:0]   <= RW0_wdata[257:0];
                if (RW0_wmask[1]) mem[RW0_addr][515:258] <= RW0_wdata[515:258];
            end else begin
                RW0_rdata <= mem[RW0_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; wr_mask = 2'b11;
        tick(); tick();
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b expected 0", rd_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (RW0_en !== 1'b0) begin errors++; $display("FAIL reset_RW0_en: got %b expected 0", RW0_en); end
        tick();
        rd_valid = 1'b0; reset = 1'b0; wr_addr = 5'd0; wr_data = '0;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_resp_valid: got %b expected 0", resp_valid); end
        tick();
        idle();
    endtask

    task automatic test_write_read();
        resp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 5'd3; wr_mask = 2'b11; wr_data = pat_a;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_grant: got %b expected 1", wr_ready); end
        checks++; if ({RW0_en, RW0_wmode, RW0_addr, RW0_wmask} !== {1'b1, 1'b1, 5'd3, 2'b11}) begin
            errors++; $display("FAIL wr_cmd: got en%b wm%b a%0d m%b expected en1 wm1 a3 m11", RW0_en, RW0_wmode, RW0_addr, RW0_wmask); end
        checks++; if (RW0_wdata !== pat_a) begin errors++; $display("FAIL wr_wdata: got %h expected %h", RW0_wdata, pat_a); end
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5'd3;
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rd_grant: got %b expected 1", rd_ready); end
        checks++; if ({RW0_en, RW0_wmode, RW0_addr} !== {1'b1, 1'b0, 5'd3}) begin
            errors++; $display("FAIL rd_cmd: got en%b wm%b a%0d expected en1 wm0 a3", RW0_en, RW0_wmode, RW0_addr); end
        tick();
        rd_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lat1_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (RW0_en !== 1'b0 || RW0_addr !== 5'd0) begin errors++; $display("FAIL idle_cmd: got en%b a%0d expected en0 a0", RW0_en, RW0_addr); end
        tick();
        #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lat2_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_data !== pat_a) begin errors++; $display("FAIL lat2_resp_data: got %h expected %h", resp_data, pat_a); end
        tick();
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL drained_resp_valid: got %b expected 0", resp_valid); end
    endtask

    task automatic test_partial_mask();
        wr_valid = 1'b1; wr_addr = 5'd7; wr_mask = 2'b11; wr_data = pat_a;
        tick();
        wr_mask = 2'b01; wr_data = pat_b;
        #1;
        checks++; if (RW0_wmask !== 2'b01) begin errors++; $display("FAIL partial_wmask: got %b expected 01", RW0_wmask); end
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5'd7;
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL partial_rd_grant: got %b expected 1", rd_ready); end
        tick();
        rd_valid = 1'b0;
        tick();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== pat_mix) begin
            errors++; $display("FAIL partial_resp: got v%b %h expected v1 %h", resp_valid, resp_data, pat_mix); end
        tick();
    endtask

    task automatic test_mask_zero();
        wr_valid = 1'b1; wr_addr = 5'd3; wr_mask = 2'b00; wr_data = pat_b;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL mask0_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (RW0_en !== 1'b0) begin errors++; $display("FAIL mask0_RW0_en: got %b expected 0", RW0_en); end
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5'd3;
        tick();
        rd_valid = 1'b0;
        tick();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== pat_a) begin
            errors++; $display("FAIL mask0_unchanged: got v%b %h expected v1 %h", resp_valid, resp_data, pat_a); end
        tick();
    endtask

    task automatic test_starvation();
        resp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 5'd20; wr_mask = 2'b11; wr_data = pat_c;
        rd_valid = 1'b1; rd_addr = 5'd3;
        for (int i = 0; i < 10; i++) begin
            logic exp_rd;
            exp_rd = (i == 4) || (i == 9);
            #1;
            checks++; if (rd_ready !== exp_rd || wr_ready !== !exp_rd) begin
                errors++; $display("FAIL starve_cycle%0d: got wr%b rd%b expected wr%b rd%b", i, wr_ready, rd_ready, !exp_rd, exp_rd); end
            tick();
        end
        idle();
        tick(); tick(); tick();
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL starve_drain: got %b expected 0", resp_valid); end
    endtask

    task automatic test_backpressure();
        wr_valid = 1'b1; wr_mask = 2'b11;
        wr_addr = 5'd1; wr_data = pat_d1; tick();
        wr_addr = 5'd2; wr_data = pat_d2; tick();
        wr_addr = 5'd4; wr_data = pat_d3; tick();
        wr_valid = 1'b0; resp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 5'd1;
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL bp_rd1: got %b expected 1", rd_ready); end
        tick();
        rd_addr = 5'd2;
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL bp_rd2: got %b expected 1", rd_ready); end
        tick();
        rd_addr = 5'd4;
        #1;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL bp_rd3_blocked: got %b expected 0", rd_ready); end
        tick();
        #1;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL bp_rd3_still_blocked: got %b expected 0", rd_ready); end
        checks++; if (resp_valid !== 1'b1 || resp_data !== pat_d1) begin
            errors++; $display("FAIL bp_head1: got v%b %h expected v1 %h", resp_valid, resp_data, pat_d1); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL bp_rd3_after_pop: got %b expected 1", rd_ready); end
        checks++; if (resp_data !== pat_d2) begin errors++; $display("FAIL bp_head2: got %h expected %h", resp_data, pat_d2); end
        tick();
        rd_valid = 1'b0; resp_ready = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== pat_d2) begin
            errors++; $display("FAIL bp_order2: got v%b %h expected v1 %h", resp_valid, resp_data, pat_d2); end
        tick();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== pat_d3) begin
            errors++; $display("FAIL bp_order3: got v%b %h expected v1 %h", resp_valid, resp_data, pat_d3); end
        tick();
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", resp_valid); end
    endtask

    task automatic test_reset_inflight();
        resp_ready = 1'b1;
        rd_valid = 1'b1; rd_addr = 5'd3;
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rst_rd_grant: got %b expected 1", rd_ready); end
        tick();
        idle(); reset = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b0 || RW0_en !== 1'b0) begin
            errors++; $display("FAIL rst_during: got v%b en%b expected v0 en0", resp_valid, RW0_en); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_discard%0d: got %b expected 0", i, resp_valid); end
            tick();
        end
        resp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 5'd7;
        tick();
        rd_addr = 5'd1;
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rst_credit_restored: got %b expected 1", rd_ready); end
        tick();
        rd_valid = 1'b0;
        tick();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== pat_mix) begin
            errors++; $display("FAIL rst_post_read: got v%b %h expected v1 %h", resp_valid, resp_data, pat_mix); end
        resp_ready = 1'b1;
        tick();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== pat_d1) begin
            errors++; $display("FAIL rst_post_read2: got v%b %h expected v1 %h", resp_valid, resp_data, pat_d1); end
        tick();
    endtask

    initial begin
        pat_a   = {129{4'hA}};
        pat_b   = {129{4'h5}};
        pat_c   = {129{4'hC}};
        pat_d1  = {129{4'h1}};
        pat_d2  = {129{4'h2}};
        pat_d3  = {129{4'h3}};
        pat_mix = {pat_a[515:258], pat_b[257:0]};
        reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b0;
        wr_addr = '0; wr_mask = '0; wr_data = '0; rd_addr = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_partial_mask();
        test_mask_zero();
        test_starvation();
        test_backpressure();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
